carregador_programa: RTL and testbench
======================================

CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, giving the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 6, giving the word-address width, with 2**ADDR_W >= MEM_WORDS.
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port byte_in, input, 8 bits: program stream byte.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-007 SHALL have port byte_ready, output, 1 bit: block can accept a byte.
REQ-008 SHALL have port mem_we, output, 1 bit: instruction memory write strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: instruction memory word address.
REQ-010 SHALL have port mem_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port proc_reset, output, 1 bit: active-high reset driven to the processor.
REQ-012 SHALL have port load_done, output, 1 bit: program loaded and checksum verified.
REQ-013 SHALL have port load_error, output, 1 bit: load aborted.
REQ-014 SHALL have port words_loaded, output, ADDR_W+1 bits: count of words written so far.

Function
REQ-015 SHALL accept a byte only on a rising clock edge where byte_valid=1 and byte_ready=1; byte_in SHALL be ignored otherwise.
REQ-016 SHALL interpret the stream as follows: count byte N, then 4*N data bytes, then one checksum byte.
REQ-017 SHALL implement the states IDLE (expect count), LOAD (expect data), CHECK (expect checksum), DONE and ERROR.
REQ-018 SHALL, in IDLE on accepting count N: go to ERROR if N > MEM_WORDS, go to CHECK if N = 0, and otherwise go to LOAD.
REQ-019 SHALL assemble each data word little-endian: the first byte of the word becomes bits [7:0] and the fourth byte becomes bits [31:24].
REQ-020 SHALL, in the cycle after the 4th byte of word k is accepted, drive mem_we=1 for exactly 1 cycle with mem_addr=k and mem_wdata set to the assembled word; words SHALL be written in address order starting at k=0.
REQ-021 SHALL increment words_loaded in the same cycle as each mem_we pulse; mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-022 SHALL keep byte_ready=1 while a write is pending; a new byte SHALL be acceptable on every cycle, with no throughput loss.
REQ-023 SHALL go from LOAD to CHECK after the 4*N-th data byte is accepted.
REQ-024 SHALL maintain a running checksum as the 8-bit XOR of all data bytes; the count byte SHALL be excluded; with N=0 the expected checksum SHALL be 0x00.
REQ-025 SHALL, in CHECK on accepting the checksum byte, go to DONE on a match and to ERROR on a mismatch; the transition SHALL take effect on that same edge.
REQ-026 SHALL, in DONE, drive load_done=1, proc_reset=0 and byte_ready=0, and SHALL remain in DONE until reset.
REQ-027 SHALL, in ERROR, drive load_error=1, proc_reset=1 and byte_ready=0, and SHALL remain in ERROR until reset.
REQ-028 SHALL keep proc_reset=1 in every state other than DONE.
REQ-029 SHALL drive byte_ready=1 in IDLE, LOAD and CHECK.
REQ-030 SHALL register all outputs; byte_ready SHALL rise on the first rising edge after reset is released.
REQ-031 SHALL require a final mem_we pulse to complete before DONE is entered, so that the processor is never released before its last instruction is written.

Reset
REQ-032 SHALL, while reset=0, set state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, proc_reset=1, load_done=0, load_error=0, words_loaded=0, clear the checksum, and clear the byte/word counters.
REQ-033 SHALL, on reset assertion mid-load, abandon any partial word without writing it; words already written to memory SHALL NOT be cleared, and the next load SHALL restart at address 0.

Verification
REQ-034 SHALL be verified by: stream 01,13,00,00,00,13 -> one mem_we at addr 0 with data 0x00000013; words_loaded=1; load_done=1; proc_reset=0.
REQ-035 SHALL be verified by: stream 02,13,00,00,00,B3,00,00,00,A0 with byte_valid gaps of 0-3 cycles -> writes addr 0 = 0x00000013 and addr 1 = 0x000000B3; load_done=1.
REQ-036 SHALL be verified by: stream 01,13,00,00,00,FF -> one write occurs; load_error=1; proc_reset stays 1; byte_ready=0; further bytes are ignored.
REQ-037 SHALL be verified by: count 0x41 (65) with MEM_WORDS=64 -> ERROR on the next edge; no mem_we pulse.
REQ-038 SHALL be verified by: stream 00,00 -> DONE with no writes; words_loaded=0.
REQ-039 SHALL be verified by: reset=0 after 2 data bytes of word 0 -> all outputs take their reset values; a subsequent full valid stream loads correctly from addr 0.

Source files
------------

// File: rtl/carregador_programa_if.sv
// Program-loader bus bundle: inbound byte stream (valid/ready) plus the
// outbound instruction-memory write port. The loader side uses "master",
// the stream source / memory side uses "slave".
interface carregador_programa_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/carregador_programa.sv
// Program loader: receives "count N, 4*N data bytes (little-endian words),
// XOR checksum" over a byte stream, writes the words to instruction memory
// from address 0 and releases the processor reset only after a verified load.
module carregador_programa #(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    carregador_programa_if.master bus,
    output logic                  proc_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_W:0]       words_loaded
);

    // Word counter must hold both ADDR_W+1 bit word counts and any 8-bit N.
    localparam int unsigned CW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              proc_reset_q, proc_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [CW-1:0]     n_words_q, n_words_d;

    logic              accept;
    logic [CW-1:0]     word_cnt_inc;

    assign accept       = bus.byte_valid & byte_ready_q;
    assign word_cnt_inc = word_cnt_q + CW'(1);

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign proc_reset     = proc_reset_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
    assign words_loaded   = word_cnt_q[ADDR_W:0];

    // State and output registers; partial words are dropped on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            proc_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            csum_q       <= '0;
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
            word_cnt_q   <= '0;
            n_words_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            proc_reset_q <= proc_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            csum_q       <= csum_d;
            byte_cnt_q   <= byte_cnt_d;
            word_buf_q   <= word_buf_d;
            word_cnt_q   <= word_cnt_d;
            n_words_q    <= n_words_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state
    // so that status flags change on the very edge that moves the FSM.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        csum_d      = csum_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        word_cnt_d  = word_cnt_q;
        n_words_d   = n_words_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_words_d = CW'(bus.byte_in);
                    if ({24'd0, bus.byte_in} > MEM_WORDS) begin
                        state_d = ERROR;
                    end else if (bus.byte_in == 8'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.byte_in;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte: the write strobe fires in the next cycle
                        // while the stream keeps flowing.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {bus.byte_in, word_buf_q};
                        word_cnt_d  = word_cnt_inc;
                        byte_cnt_d  = 2'd0;
                        if (word_cnt_inc == n_words_q) begin
                            state_d = CHECK;
                        end
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    word_buf_d[7:0]   = bus.byte_in;
                            2'd1:    word_buf_d[15:8]  = bus.byte_in;
                            default: word_buf_d[23:16] = bus.byte_in;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            CHECK: begin
                // The last write strobe always ends before a checksum byte can
                // be accepted, so the processor sees a fully written memory.
                if (accept) begin
                    state_d = (bus.byte_in == csum_q) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        byte_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == CHECK);
        proc_reset_d = (state_d != DONE);
        load_done_d  = (state_d == DONE);
        load_error_d = (state_d == ERROR);
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for the program loader with a write scoreboard.
module tb_carregador_programa;

    logic       clock;
    logic       reset;
    logic       proc_reset;
    logic       load_done;
    logic       load_error;
    logic [6:0] words_loaded;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [6:0]  wl;
    } wr_t;

    wr_t exp_q[$];

    carregador_programa_if #(.ADDR_W(6)) bus ();

    carregador_programa #(.MEM_WORDS(64), .ADDR_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .proc_reset   (proc_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every write strobe must match the next scoreboard entry.
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       bus.mem_addr, bus.mem_wdata);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("write_data", bus.mem_wdata, e.data);
                chk("write_words_loaded", 32'(words_loaded), 32'(e.wl));
                $display("write addr=%0d data=%h words_loaded=%0d", bus.mem_addr, bus.mem_wdata, words_loaded);
            end
        end
    end

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d, input logic [6:0] wl);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.wl   = wl;
        exp_q.push_back(e);
    endtask

    // Offer one byte, wait (bounded) for acceptance, then idle for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit must_be_immediate);
        int waited;
        waited = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(negedge clock);
        while (bus.byte_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clock);
        end
        if (waited >= 20) begin
            n_assert++;
            n_fail++;
            $display("FAIL byte_accept_timeout: observed byte_ready=%b expected 1", bus.byte_ready);
        end
        @(posedge clock);
        #1;
        $display("byte %h accepted after %0d wait cycles", b, waited);
        if (must_be_immediate) chk("no_stall", 32'(waited), 32'd0);
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_reset", 32'(bus.byte_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_proc_reset"}, 32'(proc_reset), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        logic [7:0] s35 [10];
        s35 = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'hA0};

        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        #12;
        check_reset_values("reset");

        // Single word, back-to-back bytes.
        apply_reset();
        push_wr(6'd0, 32'h0000_0013, 7'd1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        chk("one_word_done", 32'(load_done), 32'd1);
        chk("one_word_proc_reset", 32'(proc_reset), 32'd0);
        chk("one_word_ready", 32'(bus.byte_ready), 32'd0);
        chk("one_word_count", 32'(words_loaded), 32'd1);
        chk("one_word_addr_hold", 32'(bus.mem_addr), 32'd0);
        chk("one_word_data_hold", bus.mem_wdata, 32'h0000_0013);
        chk("one_word_drained", 32'(exp_q.size()), 32'd0);

        // Two words with random valid gaps.
        apply_reset();
        push_wr(6'd0, 32'h0000_0013, 7'd1);
        push_wr(6'd1, 32'h0000_00B3, 7'd2);
        for (int i = 0; i < 10; i++) send_byte(s35[i], int'($urandom_range(3, 0)), 1'b0);
        chk("two_word_done", 32'(load_done), 32'd1);
        chk("two_word_error", 32'(load_error), 32'd0);
        chk("two_word_count", 32'(words_loaded), 32'd2);
        chk("two_word_drained", 32'(exp_q.size()), 32'd0);

        // Bad checksum.
        apply_reset();
        push_wr(6'd0, 32'h0000_0013, 7'd1);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        chk("bad_csum_error", 32'(load_error), 32'd1);
        chk("bad_csum_done", 32'(load_done), 32'd0);
        chk("bad_csum_proc_reset", 32'(proc_reset), 32'd1);
        chk("bad_csum_ready", 32'(bus.byte_ready), 32'd0);
        bus.byte_in    = 8'h01;
        bus.byte_valid = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        bus.byte_valid = 1'b0;
        chk("bad_csum_sticky_error", 32'(load_error), 32'd1);
        chk("bad_csum_ignored_count", 32'(words_loaded), 32'd1);
        chk("bad_csum_drained", 32'(exp_q.size()), 32'd0);

        // Oversized count.
        apply_reset();
        send_byte(8'h41, 0, 1'b0);
        chk("oversize_error", 32'(load_error), 32'd1);
        chk("oversize_ready", 32'(bus.byte_ready), 32'd0);
        bus.byte_in    = 8'h13;
        bus.byte_valid = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        bus.byte_valid = 1'b0;
        chk("oversize_count", 32'(words_loaded), 32'd0);

        // Maximum count accepted: 64 words must not raise an error.
        apply_reset();
        send_byte(8'h40, 0, 1'b0);
        chk("max_count_no_error", 32'(load_error), 32'd0);
        chk("max_count_ready", 32'(bus.byte_ready), 32'd1);

        // Empty program.
        apply_reset();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        chk("empty_done", 32'(load_done), 32'd1);
        chk("empty_proc_reset", 32'(proc_reset), 32'd0);
        chk("empty_count", 32'(words_loaded), 32'd0);

        // Reset in the middle of word 0, then a clean reload.
        apply_reset();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        apply_reset();
        push_wr(6'd0, 32'h1234_5678, 7'd1);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h78, 0, 1'b0);
        send_byte(8'h56, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h08, 0, 1'b0);
        chk("reload_done", 32'(load_done), 32'd1);
        chk("reload_count", 32'(words_loaded), 32'd1);
        chk("reload_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
